// File: rtl/nanorv32_intc_if.sv
// nanorv32_intc_if: core handshake (irq/ack/reti) and register port of the interrupt controller.
// Latency: none, wires only.
// Backpressure: irq is held by the controller until the core pulses irq_ack.
interface nanorv32_intc_if #(
   parameter int IDW = 5
);
   logic           irq;
   logic           irq_ack;
   logic           reti_inst_detected;
   logic [IDW-1:0] irq_id;
   logic           irq_active;
   logic           reg_sel;
   logic           reg_wr;
   logic [1:0]     reg_addr;
   logic [31:0]    reg_wdata;
   logic [31:0]    reg_rdata;

   // core / bus side
   modport master (
      input  irq, irq_id, irq_active, reg_rdata,
      output irq_ack, reti_inst_detected, reg_sel, reg_wr, reg_addr, reg_wdata
   );

   // interrupt controller side
   modport slave (
      output irq, irq_id, irq_active, reg_rdata,
      input  irq_ack, reti_inst_detected, reg_sel, reg_wr, reg_addr, reg_wdata
   );
endinterface

// File: rtl/nanorv32_intc.sv
// nanorv32_intc: edge-latched, enable-masked, fixed-priority (index 0 first) interrupt controller.
// Latency: source edge sampled at k -> irq high after k+2 (k+4 with NANORV32_INTC_SYNC_EN defined).
// Backpressure: irq holds until irq_ack; no nesting, later requests wait for reti_inst_detected.
module nanorv32_intc #(
   parameter int NB_IRQ = 8,
   parameter int IDW    = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NB_IRQ-1:0] irq_src,
   nanorv32_intc_if.slave    bus
);
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } state_t;

   localparam logic [1:0] A_ENABLE  = 2'd0;
   localparam logic [1:0] A_PENDING = 2'd1;
   localparam logic [1:0] A_ACTIVE  = 2'd2;

   state_t            state;
   state_t            state_nxt;
   logic [NB_IRQ-1:0] src_in;
   logic [NB_IRQ-1:0] src_q;
   logic [NB_IRQ-1:0] src_rise;
   logic [NB_IRQ-1:0] pending;
   logic [NB_IRQ-1:0] enable;
   logic [NB_IRQ-1:0] req;
   logic [NB_IRQ-1:0] set_mask;
   logic [NB_IRQ-1:0] clr_mask;
   logic [NB_IRQ-1:0] wdata_lo;
   logic              req_any;
   logic              reg_we;
   logic              take;
   logic              eoi;
   logic              irq_q;
   logic              irq_nxt;
   logic              active_q;
   logic [IDW-1:0]    id_q;
   logic [IDW-1:0]    winner;
   logic [31:0]       rdata;

`ifdef NANORV32_INTC_SYNC_EN
   logic [NB_IRQ-1:0] sync_ff1;
   logic [NB_IRQ-1:0] sync_ff2;

   // two-flop synchronizer for sources not timed to clk
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_ff1 <= '0;
         sync_ff2 <= '0;
      end else begin
         sync_ff1 <= irq_src;
         sync_ff2 <= sync_ff1;
      end
   end
   assign src_in = sync_ff2;
`else
   assign src_in = irq_src;
`endif

   generate
      if (NB_IRQ < 32) begin : g_unused_wdata
         logic unused_wdata;
         assign unused_wdata = ^bus.reg_wdata[31:NB_IRQ];
      end
   endgenerate

   assign wdata_lo = bus.reg_wdata[NB_IRQ-1:0];
   assign reg_we   = bus.reg_sel & bus.reg_wr;
   assign src_rise = src_in & ~src_q;
   assign req      = pending & enable;
   assign req_any  = |req;

   // lowest set index of the request vector wins
   always_comb begin
      winner = '0;
      for (int i = NB_IRQ - 1; i >= 0; i--) begin
         if (req[i]) winner = IDW'(i);
      end
   end

   // set sources (edges, SWTRIG) and clear sources (W1C, ack); set wins on overlap
   always_comb begin
      set_mask = src_rise;
      clr_mask = '0;
      if (reg_we && bus.reg_addr == 2'd3) set_mask = set_mask | wdata_lo;
      if (reg_we && bus.reg_addr == A_PENDING) clr_mask = wdata_lo;
      if (take) clr_mask = clr_mask | (NB_IRQ'(1) << winner);
   end

   // edge history, pending latch and software enable register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         src_q   <= '0;
         pending <= '0;
         enable  <= '0;
      end else begin
         src_q   <= src_in;
         pending <= (pending & ~clr_mask) | set_mask;
         if (reg_we && bus.reg_addr == A_ENABLE) enable <= wdata_lo;
      end
   end

   // state register plus the registered core-facing outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         irq_q    <= 1'b0;
         id_q     <= '0;
         active_q <= 1'b0;
      end else begin
         state <= state_nxt;
         irq_q <= irq_nxt;
         if (take) begin
            id_q     <= winner;
            active_q <= 1'b1;
         end else if (eoi) begin
            active_q <= 1'b0;
         end
      end
   end

   // next-state: request while anything is enabled+pending, hold service until reti
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req_any) state_nxt = REQ;
         REQ: begin
            if (take)          state_nxt = SERVICE;
            else if (!req_any) state_nxt = IDLE;
         end
         SERVICE: if (bus.reti_inst_detected) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // outputs: ack accepted only in REQ, irq rises one cycle after entering REQ
   always_comb begin
      take    = 1'b0;
      eoi     = 1'b0;
      irq_nxt = 1'b0;
      case (state)
         REQ: begin
            take    = bus.irq_ack & req_any;
            irq_nxt = (state_nxt == REQ);
         end
         SERVICE: eoi = bus.reti_inst_detected;
         default: ;
      endcase
   end

   // register read mux, unused bits read as zero
   always_comb begin
      rdata = '0;
      case (bus.reg_addr)
         A_ENABLE:  rdata[NB_IRQ-1:0] = enable;
         A_PENDING: rdata[NB_IRQ-1:0] = pending;
         A_ACTIVE: begin
            rdata[31]      = active_q;
            rdata[IDW-1:0] = id_q;
         end
         default: rdata = '0;
      endcase
   end

   assign bus.irq        = irq_q;
   assign bus.irq_id     = id_q;
   assign bus.irq_active = active_q;
   assign bus.reg_rdata  = rdata;
endmodule
